// File: rtl/imem_loadable.sv
// Loadable instruction memory: words streamed in over valid/ready, fetched with one-cycle latency.
// Optional build macro IMEM_BYTE_PC_EN: treat i_pc as a byte address with an alignment check.
module imem_loadable #(
   parameter int                DATA_WIDTH = 32,
   parameter int                DEPTH      = 64,
   parameter int                ADDR_WIDTH = 6,
   parameter int                SIZEOP     = 6,
   parameter logic [SIZEOP-1:0] HALT_OP    = {SIZEOP{1'b1}}
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_load_start,
   input  logic                  i_load_valid,
   input  logic [DATA_WIDTH-1:0] i_load_data,
   output logic                  o_load_ready,
   input  logic                  i_load_done,
   input  logic                  i_fetch_en,
   input  logic [DATA_WIDTH-1:0] i_pc,
   output logic [DATA_WIDTH-1:0] o_instruccion,
   output logic                  o_instr_valid,
   output logic                  o_haltsignal,
   output logic                  o_pc_error,
   output logic [ADDR_WIDTH:0]   o_load_count,
   output logic [1:0]            o_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_RUN    = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

   state_e                state_q;
   logic [ADDR_WIDTH:0]   count_q;
   logic [DATA_WIDTH-1:0] instr_q;
   logic                  valid_q;
   logic                  halt_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [DATA_WIDTH-1:0] widx;
   logic                  misalign;
   logic [DATA_WIDTH-1:0] count_ext;
   logic                  out_of_range;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  fetch_halt;
   logic                  load_accept;

`ifdef IMEM_BYTE_PC_EN
   assign widx     = {2'b00, i_pc[DATA_WIDTH-1:2]};
   assign misalign = |i_pc[1:0];
`else
   assign widx     = i_pc;
   assign misalign = 1'b0;
`endif

   // Range check uses the full word index so high PC bits cannot alias into loaded words
   assign count_ext    = {{(DATA_WIDTH-ADDR_WIDTH-1){1'b0}}, count_q};
   assign out_of_range = misalign | (widx >= count_ext);
   assign rd_word      = mem_q[widx[ADDR_WIDTH-1:0]];
   assign fetch_halt   = !out_of_range && (rd_word[DATA_WIDTH-1 -: SIZEOP] == HALT_OP);

   assign o_load_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
   assign load_accept  = o_load_ready && i_load_valid && !i_load_start;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         halt_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (i_load_start) begin
         state_q <= ST_LOAD;
         count_q <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         halt_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
               valid_q <= 1'b0;
               if (load_accept) count_q <= count_q + 1'b1;
               if (i_load_done) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (i_fetch_en) begin
                  valid_q <= 1'b1;
                  err_q   <= out_of_range;
                  instr_q <= out_of_range ? '0 : rd_word;
                  if (fetch_halt) begin
                     halt_q  <= 1'b1;
                     state_q <= ST_HALTED;
                  end
               end else begin
                  valid_q <= 1'b0;
               end
            end
            ST_HALTED: valid_q <= 1'b0;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   // Array has no reset so it maps onto plain RAM; stale words stay hidden behind count_q
   always_ff @(posedge i_clock) begin
      if (load_accept) mem_q[count_q[ADDR_WIDTH-1:0]] <= i_load_data;
   end

   assign o_instruccion = instr_q;
   assign o_instr_valid = valid_q;
   assign o_haltsignal  = halt_q;
   assign o_pc_error    = err_q;
   assign o_load_count  = count_q;
   assign o_state       = state_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed + randomized bench for imem_loadable against a word-level reference model.
module tb_imem_loadable;
   localparam int DW    = 32;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          i_clock = 1'b0;
   logic          i_reset = 1'b0;
   logic          i_load_start = 1'b0;
   logic          i_load_valid = 1'b0;
   logic [DW-1:0] i_load_data = '0;
   logic          o_load_ready;
   logic          i_load_done = 1'b0;
   logic          i_fetch_en = 1'b0;
   logic [DW-1:0] i_pc = '0;
   logic [DW-1:0] o_instruccion;
   logic          o_instr_valid;
   logic          o_haltsignal;
   logic          o_pc_error;
   logic [AW:0]   o_load_count;
   logic [1:0]    o_state;

   imem_loadable dut (
      .i_clock(i_clock), .i_reset(i_reset),
      .i_load_start(i_load_start), .i_load_valid(i_load_valid),
      .i_load_data(i_load_data), .o_load_ready(o_load_ready),
      .i_load_done(i_load_done), .i_fetch_en(i_fetch_en), .i_pc(i_pc),
      .o_instruccion(o_instruccion), .o_instr_valid(o_instr_valid),
      .o_haltsignal(o_haltsignal), .o_pc_error(o_pc_error),
      .o_load_count(o_load_count), .o_state(o_state)
   );

   always #5 i_clock = ~i_clock;

   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] ref_mem [DEPTH];
   int            ref_n = 0;
   logic [DW-1:0] last_instr = '0;
   logic          last_err = 1'b0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clock);
      #1;
   endtask

   function automatic logic [DW-1:0] pc_of(input int idx);
`ifdef IMEM_BYTE_PC_EN
      return DW'(idx) << 2;
`else
      return DW'(idx);
`endif
   endfunction

   function automatic logic [DW-1:0] rand_word();
      return $urandom & 32'hF7FF_FFFF;   // bit 27 cleared: never the halt opcode
   endfunction

   function automatic logic [DW-1:0] exp_word(input int idx);
      return (idx < ref_n) ? ref_mem[idx] : '0;
   endfunction

   task automatic fetch(input int idx, input string tag);
      logic [DW-1:0] e;
      logic          h;
      e = exp_word(idx);
      h = (idx < ref_n) && (e[31:26] == 6'h3F);
      i_fetch_en = 1'b1;
      i_pc       = pc_of(idx);
      step();
      i_fetch_en = 1'b0;
      check({tag, "_instr"}, o_instruccion, e);
      check({tag, "_err"},   DW'(o_pc_error), DW'(idx >= ref_n));
      check({tag, "_valid"}, DW'(o_instr_valid), 1);
      check({tag, "_halt"},  DW'(o_haltsignal), DW'(h));
      check({tag, "_state"}, DW'(o_state), h ? 3 : 2);
      last_instr = e;
      last_err   = (idx >= ref_n);
   endtask

   task automatic load_prog(input logic [DW-1:0] words[$], input bit done_with_last, input string tag);
      i_load_start = 1'b1;
      step();
      i_load_start = 1'b0;
      check({tag, "_ld_state"}, DW'(o_state), 1);
      check({tag, "_ld_count"}, DW'(o_load_count), 0);
      check({tag, "_ld_ready"}, DW'(o_load_ready), 1);
      check({tag, "_ld_halt"},  DW'(o_haltsignal), 0);
      check({tag, "_ld_instr"}, o_instruccion, 0);
      ref_n = 0;
      foreach (words[k]) begin
         i_load_valid = 1'b1;
         i_load_data  = words[k];
         if (done_with_last && k == words.size() - 1) i_load_done = 1'b1;
         step();
         ref_mem[ref_n] = words[k];
         ref_n++;
      end
      i_load_valid = 1'b0;
      if (!done_with_last || words.size() == 0) begin
         i_load_done = 1'b1;
         step();
      end
      i_load_done = 1'b0;
      check({tag, "_run_state"}, DW'(o_state), 2);
      check({tag, "_run_count"}, DW'(o_load_count), DW'(ref_n));
      last_instr = '0;
      last_err   = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] q[$];
      logic [DW-1:0] d;
      int            idx;
      bit            en;

      // Reset and idle behaviour
      step();
      step();
      check("rst_state", DW'(o_state), 0);
      check("rst_instr", o_instruccion, 0);
      check("rst_valid", DW'(o_instr_valid), 0);
      check("rst_halt",  DW'(o_haltsignal), 0);
      check("rst_err",   DW'(o_pc_error), 0);
      check("rst_count", DW'(o_load_count), 0);
      check("rst_ready", DW'(o_load_ready), 0);
      i_reset    = 1'b1;
      i_fetch_en = 1'b1;
      i_pc       = '0;
      step();
      i_fetch_en = 1'b0;
      check("idle_valid", DW'(o_instr_valid), 0);
      check("idle_instr", o_instruccion, 0);
      check("idle_state", DW'(o_state), 0);

      // Three-word program ending in halt
      q = '{32'h2001_0005, 32'h2002_0003, 32'hFC00_0000};
      load_prog(q, 1'b0, "prog");
      fetch(0, "p0");
      fetch(1, "p1");
      fetch(2, "p2");
      i_fetch_en = 1'b1;
      i_pc       = pc_of(0);
      step();
      i_fetch_en = 1'b0;
      check("halted_valid", DW'(o_instr_valid), 0);
      check("halted_instr", o_instruccion, 32'hFC00_0000);
      check("halted_flag",  DW'(o_haltsignal), 1);
      check("halted_state", DW'(o_state), 3);

      // Reload from HALTED, out-of-range fetch, stall hold
      q = '{rand_word(), rand_word(), rand_word()};
      load_prog(q, 1'b0, "rl");
      fetch(5, "oor");
      fetch(1, "in1");
      fetch(0, "in0");
      for (int s = 0; s < 3; s++) begin
         step();
         check("stall_instr", o_instruccion, last_instr);
         check("stall_valid", DW'(o_instr_valid), 0);
      end

      // Random fetch/stall mix
      for (int r = 0; r < 12; r++) begin
         en  = 1'($urandom_range(0, 1));
         idx = int'($urandom_range(0, 5));
         if (en) begin
            fetch(idx, "rnd");
         end else begin
            i_pc = pc_of(idx);
            step();
            check("rnd_hold_instr", o_instruccion, last_instr);
            check("rnd_hold_err",   DW'(o_pc_error), DW'(last_err));
            check("rnd_hold_valid", DW'(o_instr_valid), 0);
         end
      end

      // Overfill: DEPTH+2 words with valid held high
      i_load_start = 1'b1;
      step();
      i_load_start = 1'b0;
      ref_n = 0;
      for (int k = 0; k < DEPTH + 2; k++) begin
         d            = rand_word();
         i_load_valid = 1'b1;
         i_load_data  = d;
         #1;
         check("fill_ready", DW'(o_load_ready), DW'(ref_n < DEPTH));
         step();
         if (ref_n < DEPTH) begin
            ref_mem[ref_n] = d;
            ref_n++;
         end
      end
      i_load_valid = 1'b0;
      check("fill_count", DW'(o_load_count), DEPTH);
      check("fill_ready_end", DW'(o_load_ready), 0);
      i_load_done = 1'b1;
      step();
      i_load_done = 1'b0;
      fetch(DEPTH - 1, "fill_last");
      fetch(0, "fill_first");
      fetch(DEPTH, "fill_over");

      // Word accepted in the same cycle as done
      q = '{rand_word(), rand_word()};
      load_prog(q, 1'b1, "dl");
      fetch(1, "dl1");
      fetch(2, "dl2");

      // Asynchronous reset in the middle of a load
      i_load_start = 1'b1;
      step();
      i_load_start = 1'b0;
      i_load_valid = 1'b1;
      i_load_data  = rand_word();
      step();
      i_load_data  = rand_word();
      step();
      i_load_valid = 1'b0;
      #3;
      i_reset = 1'b0;
      #1;
      check("arst_count", DW'(o_load_count), 0);
      check("arst_state", DW'(o_state), 0);
      check("arst_ready", DW'(o_load_ready), 0);
      step();
      i_reset = 1'b1;
      q.delete();
      load_prog(q, 1'b0, "empty");
      fetch(0, "empty0");

`ifdef IMEM_BYTE_PC_EN
      // Misaligned byte address
      q = '{rand_word(), rand_word(), rand_word()};
      load_prog(q, 1'b0, "byte");
      fetch(2, "pc8");
      i_fetch_en = 1'b1;
      i_pc       = 32'd6;
      step();
      i_fetch_en = 1'b0;
      check("mis_instr", o_instruccion, 0);
      check("mis_err",   DW'(o_pc_error), 1);
      check("mis_valid", DW'(o_instr_valid), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised instruction memory for the MIPS fetch stage, loaded word-by-word over a valid/ready stream from the debug/loader unit and read by the PC with one-cycle registered latency. It adds a load/run/halt state machine, a stall input, out-of-range PC detection and a sticky halt flag that stops fetching until the memory is reloaded. It sits between the loader and the IF/ID pipeline register.

## Interface
- DATA_WIDTH, 32, instruction word width
- DEPTH, 64, number of instruction words
- ADDR_WIDTH, 6, word-index width; must equal clog2(DEPTH)
- SIZEOP, 6, opcode field width (bits [DATA_WIDTH-1 -: SIZEOP])
- HALT_OP, 6'b111111, opcode that marks end of program
- i_clock  in  1  single clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_load_start  in  1  pulse: enter LOAD, write pointer to 0
- i_load_valid  in  1  loader word valid
- i_load_data  in  DATA_WIDTH  loader word
- o_load_ready  out  1  memory accepts a word this cycle
- i_load_done  in  1  pulse: LOAD → RUN
- i_fetch_en  in  1  fetch enable; 0 = stall
- i_pc  in  DATA_WIDTH  program counter
- o_instruccion  out  DATA_WIDTH  fetched instruction
- o_instr_valid  out  1  o_instruccion is new this cycle
- o_haltsignal  out  1  sticky halt flag
- o_pc_error  out  1  last fetch was out of loaded range
- o_load_count  out  ADDR_WIDTH+1  words loaded (0..DEPTH)
- o_state  out  2  IDLE=0, LOAD=1, RUN=2, HALTED=3

## Operation
- Reset (i_reset=0): state IDLE, o_instruccion=0, o_instr_valid=0, o_haltsignal=0, o_pc_error=0, o_load_count=0. Memory array is not cleared.
- i_load_start in any state → LOAD next cycle; pointer=0, halt/error/valid cleared, o_instruccion=0. Has priority over i_load_done and fetch in the same cycle.
- LOAD: o_load_ready = (o_load_count < DEPTH), combinational from state/pointer. On valid&ready: mem[pointer] ← i_load_data, pointer+1. At DEPTH, ready=0 and further valid words are dropped. i_load_done → RUN; a word accepted in the same cycle as done is still written.
- IDLE: fetch ignored, o_load_ready=0, outputs hold.
- RUN, i_fetch_en=1: index = i_pc[ADDR_WIDTH-1:0] word index (see Configuration); if full PC word index ≥ o_load_count → o_instruccion=0 (NOP), o_pc_error=1; else o_instruccion=mem[index], o_pc_error=0. o_instr_valid=1. If fetched word's opcode == HALT_OP → o_haltsignal=1 with that word, state → HALTED.
- RUN, i_fetch_en=0: o_instruccion, o_pc_error hold; o_instr_valid=0.
- HALTED: o_instruccion holds the halt word, o_instr_valid=0, o_haltsignal=1; exits only via i_load_start or reset.

## Timing
- Fetch latency: 1 cycle (PC sampled at edge N, instruction valid after edge N).
- Load write: 1 cycle; a word written at edge N is fetchable from edge N+1 once in RUN.
- LOAD→RUN: 1 cycle after i_load_done edge; first fetch can be presented the cycle RUN is entered.
- o_haltsignal asserts in the same cycle as the halt instruction on o_instruccion; no extra fetch occurs after it.
- Asynchronous reset mid-load: pointer and count return to 0; partially written words remain but are out of range.

## Configuration
- IMEM_BYTE_PC_EN defined: i_pc is a byte address; word index = i_pc >> 2; i_pc[1:0] ≠ 0 in RUN with fetch_en also sets o_pc_error=1 and returns NOP.
- Undefined: i_pc is a word index used directly; no alignment check.

## Test plan
- Reset then fetch with i_fetch_en=1 in IDLE → o_instr_valid=0, o_instruccion=0, o_state=0.
- Start, load 0x20010005, 0x20020003, 0xFC000000, done; fetch PC 0,1,2 (word mode) → 0x20010005, 0x20020003, 0xFC000000 one cycle each, o_haltsignal=1 with the third, o_state=3, later PCs ignored.
- Load 3 words, fetch PC 5 → o_instruccion=0, o_pc_error=1; next fetch PC 1 → word 1, o_pc_error=0.
- Stream DEPTH+2 words with valid held high → o_load_ready drops after 64 words, o_load_count=64, extra words not written.
- Fetch PC 0, then i_fetch_en=0 for 3 cycles → o_instruccion holds, o_instr_valid=0 for those cycles.
- With IMEM_BYTE_PC_EN: fetch PC 8 → word 2; PC 6 → NOP, o_pc_error=1; i_load_start while HALTED → LOAD, o_haltsignal=0.
